// File: rtl/cam_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cam_capture : frame/line-synchronised camera pixel packer with output FIFO |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module cam_capture #(
  parameter int DATA_W     = 8,
  parameter int BPP        = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       cam_dat,
  input  logic                    cam_href,
  input  logic                    cam_vsync,
  input  logic                    enable,
  input  logic                    clear_ovf,
  output logic [DATA_W*BPP-1:0]   out_data,
  output logic                    out_sof,
  output logic                    out_sol,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        line_cnt,
  output logic                    overflow,
  output logic                    busy
);

  localparam int                 PIX_W     = DATA_W * BPP;
  localparam int                 ENT_W     = PIX_W + 2;
  localparam int                 AW        = $clog2(FIFO_DEPTH);
  localparam int                 BEAT_W    = 2;
  localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(BPP - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    ACTIVE     = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                vsync_q, href_q;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [PIX_W-1:0]    pack_q, pack_d;
  logic                pix_vld_q, pix_vld_d;
  logic [PIX_W-1:0]    pix_data_q, pix_data_d;
  logic                pix_sof_q, pix_sof_d;
  logic                pix_sol_q, pix_sol_d;
  logic                sof_pend_q, sof_pend_d;
  logic                sol_pend_q, sol_pend_d;
  logic [CNT_W-1:0]    line_cnt_q, line_cnt_d;
  logic                ovf_q, ovf_d;
  logic [AW:0]         wr_ptr_q, wr_ptr_d;
  logic [AW:0]         rd_ptr_q, rd_ptr_d;
  logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];

  logic                vs_fall, vs_rise, href_rise, href_fall;
  logic                active, beat_en, pix_done;
  logic [PIX_W-1:0]    pack_shift;
  logic                fifo_empty, fifo_full, pop, push, drop;
  logic                carry_sof, carry_sol;
  logic [ENT_W-1:0]    head;

  assign vs_fall    = vsync_q & ~cam_vsync;
  assign vs_rise    = ~vsync_q & cam_vsync;
  assign href_rise  = ~href_q & cam_href;
  assign href_fall  = href_q & ~cam_href;
  assign active     = (state_q == ACTIVE);
  assign beat_en    = active & cam_href;
  assign pix_done   = beat_en & (beat_q == LAST_BEAT);
  assign pack_shift = (pack_q << DATA_W) | PIX_W'(cam_dat);

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = ~fifo_empty & out_ready;
  assign push       = pix_vld_q & (~fifo_full | pop);
  assign drop       = pix_vld_q & fifo_full & ~pop;
  assign carry_sof  = drop & pix_sof_q;
  assign carry_sol  = drop & pix_sol_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (enable) state_d = WAIT_FRAME;
      WAIT_FRAME: begin
        if (!enable)      state_d = IDLE;
        else if (vs_fall) state_d = ACTIVE;
      end
      ACTIVE:     if (vs_rise) state_d = enable ? WAIT_FRAME : IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    beat_d     = beat_q;
    pack_d     = pack_q;
    pix_vld_d  = 1'b0;
    pix_data_d = pix_data_q;
    pix_sof_d  = pix_sof_q;
    pix_sol_d  = pix_sol_q;
    // A dropped pixel hands its markers to the next pixel that makes it in.
    sof_pend_d = sof_pend_q | carry_sof;
    sol_pend_d = sol_pend_q | carry_sol | href_rise;
    line_cnt_d = line_cnt_q;

    if (!active && state_d == ACTIVE) begin
      sof_pend_d = 1'b1;
      line_cnt_d = '0;
    end

    if (!active || href_fall) begin
      beat_d = '0;
    end else if (beat_en) begin
      pack_d = pack_shift;
      if (pix_done) begin
        beat_d     = '0;
        pix_vld_d  = 1'b1;
        pix_data_d = pack_shift;
        pix_sof_d  = sof_pend_q | carry_sof;
        pix_sol_d  = sol_pend_q | carry_sol | href_rise;
        sof_pend_d = 1'b0;
        sol_pend_d = 1'b0;
      end else begin
        beat_d = beat_q + 2'd1;
      end
    end

    if (active && href_fall && line_cnt_q != CNT_MAX)
      line_cnt_d = line_cnt_q + CNT_W'(1);

    ovf_d    = drop | (ovf_q & ~clear_ovf);
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      beat_q     <= '0;
      pack_q     <= '0;
      pix_vld_q  <= 1'b0;
      pix_data_q <= '0;
      pix_sof_q  <= 1'b0;
      pix_sol_q  <= 1'b0;
      sof_pend_q <= 1'b0;
      sol_pend_q <= 1'b0;
      line_cnt_q <= '0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      vsync_q    <= cam_vsync;
      href_q     <= cam_href;
      beat_q     <= beat_d;
      pack_q     <= pack_d;
      pix_vld_q  <= pix_vld_d;
      pix_data_q <= pix_data_d;
      pix_sof_q  <= pix_sof_d;
      pix_sol_q  <= pix_sol_d;
      sof_pend_q <= sof_pend_d;
      sol_pend_q <= sol_pend_d;
      line_cnt_q <= line_cnt_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset)
      mem_q[wr_ptr_q[AW-1:0]] <= {pix_sof_q, pix_sol_q, pix_data_q};
  end

  // Head fields are forced to zero while empty so stale storage never shows.
  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign out_valid = ~fifo_empty;
  assign out_data  = fifo_empty ? '0 : head[PIX_W-1:0];
  assign out_sof   = ~fifo_empty & head[PIX_W+1];
  assign out_sol   = ~fifo_empty & head[PIX_W];
  assign line_cnt  = line_cnt_q;
  assign overflow  = ovf_q;
  assign busy      = active;

endmodule
`default_nettype wire

// File: tb/tb_cam_capture.sv
`default_nettype none
// tb_cam_capture : scoreboard bench with a frame/line level reference model.
module tb_cam_capture;
  localparam int DATA_W = 8, BPP = 2, FIFO_DEPTH = 8, CNT_W = 10;
  localparam int PIX_W = DATA_W * BPP;

  logic clk = 1'b0;
  logic reset, cam_href, cam_vsync, enable, clear_ovf, out_ready;
  logic [DATA_W-1:0] cam_dat;
  logic [PIX_W-1:0] out_data;
  logic out_sof, out_sol, out_valid, overflow, busy;
  logic [CNT_W-1:0] line_cnt;

  always #5 clk = ~clk;

  cam_capture #(.DATA_W(DATA_W), .BPP(BPP), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cam_dat(cam_dat), .cam_href(cam_href),
    .cam_vsync(cam_vsync), .enable(enable), .clear_ovf(clear_ovf),
    .out_data(out_data), .out_sof(out_sof), .out_sol(out_sol),
    .out_valid(out_valid), .out_ready(out_ready), .line_cnt(line_cnt),
    .overflow(overflow), .busy(busy)
  );

  typedef logic [PIX_W+1:0] ent_t;
  ent_t sb_q[$];
  int n_cmp = 0, n_err = 0, pop_cnt = 0;
  bit model_armed = 0, model_active = 0, model_sof = 0;
  int model_lines = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic model_push(input logic [PIX_W-1:0] d, input bit first_in_line);
    sb_q.push_back({model_sof, first_in_line, d});
    model_sof = 0;
  endtask

  // Monitor: pops the scoreboard on every handshake, checks head stability.
  initial begin : monitor
    ent_t hold_ent, got, exp;
    bit hold;
    hold = 0;
    forever begin
      @(negedge clk);
      if (reset) hold = 0;
      else begin
        got = {out_sof, out_sol, out_data};
        if (hold) begin
          n_cmp++;
          if (!out_valid || got !== hold_ent) begin
            n_err++;
            $display("FAIL hold_stable: got valid=%0b ent=0x%0h expected valid=1 ent=0x%0h", out_valid, got, hold_ent);
          end
        end
        if (out_valid && out_ready) begin
          pop_cnt++;
          n_cmp++;
          if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_pixel: got ent=0x%0h expected no pixel", got);
          end else begin
            exp = sb_q.pop_front();
            if (got !== exp) begin
              n_err++;
              $display("FAIL pixel: got sof=%0b sol=%0b data=0x%0h expected sof=%0b sol=%0b data=0x%0h",
                       got[PIX_W+1], got[PIX_W], got[PIX_W-1:0], exp[PIX_W+1], exp[PIX_W], exp[PIX_W-1:0]);
            end
          end
        end
        hold = out_valid && !out_ready;
        hold_ent = got;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic set_enable(input bit v);
    enable = v; tick(); tick();
    if (!model_active) model_armed = v;
  endtask

  task automatic frame_start();
    cam_vsync = 1; repeat (3) tick();
    cam_vsync = 0; tick(); tick();
    if (model_armed) begin
      model_active = 1; model_sof = 1; model_lines = 0;
    end
  endtask

  task automatic frame_end();
    cam_vsync = 1; tick(); tick();
    if (model_active) begin
      model_active = 0; model_armed = enable;
    end
  endtask

  task automatic send_line(input int n, input bit rnd_ready);
    logic [PIX_W-1:0] acc;
    logic [DATA_W-1:0] b;
    int k, npix;
    acc = '0; k = 0; npix = 0;
    for (int j = 0; j < n; j++) begin
      b = DATA_W'($urandom);
      cam_href = 1; cam_dat = b;
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      acc = (acc << DATA_W) | PIX_W'(b);
      k++;
      if (k == BPP) begin
        if (model_active) model_push(acc, npix == 0);
        npix++; k = 0;
      end
      tick();
    end
    cam_href = 0; cam_dat = '0; tick();
    if (model_active) begin
      if (model_lines < 2**CNT_W - 1) model_lines++;
      check("line_cnt", line_cnt, model_lines);
    end
  endtask

  task automatic drain();
    int budget;
    budget = 200;
    out_ready = 1; repeat (3) tick();
    while (out_valid && budget > 0) begin tick(); budget--; end
    check("drain_empty", out_valid, 0);
    check("sb_empty", sb_q.size(), 0);
  endtask

  initial begin : stim
    int base;
    reset = 1; cam_href = 0; cam_vsync = 0; enable = 0; clear_ovf = 0;
    out_ready = 0; cam_dat = '0;
    repeat (3) tick();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_sof_sol", {out_sof, out_sol}, 0);
    check("rst_line_cnt", line_cnt, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    reset = 0; tick();

    // Basic two-pixel line with latency check
    set_enable(1);
    frame_start();
    check("busy_active", busy, 1);
    out_ready = 1;
    cam_href = 1; cam_dat = 8'h12; tick();
    cam_dat = 8'h34; model_push(16'h1234, 1); tick();
    cam_dat = 8'h56; check("latency_pre", out_valid, 0); tick();
    cam_dat = 8'h78; check("latency_2cyc", out_valid, 1); model_push(16'h5678, 0); tick();
    cam_href = 0; tick();
    model_lines = 1;
    check("line_cnt_first", line_cnt, 1);

    // Partial pixel discarded, next line flagged sol
    send_line(3, 0);
    send_line(4, 0);
    drain();
    frame_end();
    check("busy_wait", busy, 0);

    // Overflow with clear colliding with drops
    frame_start();
    out_ready = 0;
    begin
      logic [PIX_W-1:0] acc;
      logic [DATA_W-1:0] b;
      acc = '0;
      for (int j = 0; j < 20; j++) begin
        b = DATA_W'($urandom);
        cam_href = 1; cam_dat = b;
        acc = (acc << DATA_W) | PIX_W'(b);
        if ((j % BPP) == BPP - 1 && (j / BPP) < FIFO_DEPTH) model_push(acc, j == BPP - 1);
        if (j == 18) check("ovf_before_drop", overflow, 0);
        if (j == 19) check("ovf_drop_with_clear", overflow, 1);
        clear_ovf = (j == 18);
        tick();
      end
    end
    cam_href = 0; clear_ovf = 1; tick();
    clear_ovf = 0;
    check("ovf_second_drop_with_clear", overflow, 1);
    model_lines++;
    check("line_cnt_ovf", line_cnt, model_lines);
    check("full_valid", out_valid, 1);
    tick();
    check("ovf_sticky", overflow, 1);
    clear_ovf = 1; tick(); clear_ovf = 0;
    check("ovf_cleared", overflow, 0);

    // Full FIFO: write and pop in the same cycle
    cam_href = 1; cam_dat = DATA_W'($urandom); tick();
    begin
      logic [DATA_W-1:0] b0;
      b0 = DATA_W'($urandom);
      model_push({dut.pack_q[DATA_W-1:0], b0}, 1);
      cam_dat = b0;
    end
    tick();
    cam_href = 0; out_ready = 1; tick();
    out_ready = 0;
    check("ovf_full_wr_pop", overflow, 0);
    tick();
    model_lines++;
    check("line_cnt_full", line_cnt, model_lines);
    base = pop_cnt;
    drain();
    check("occupancy_full", pop_cnt - base, FIFO_DEPTH);
    check("ovf_after_drain", overflow, 0);
    frame_end();

    // Enable dropped mid-frame: frame completes, next frame ignored
    frame_start();
    send_line(6, 1);
    set_enable(0);
    check("busy_after_disable", busy, 1);
    send_line(4, 1);
    drain();
    frame_end();
    check("busy_idle", busy, 0);
    frame_start();
    check("busy_ignored_frame", busy, 0);
    send_line(6, 0);
    drain();
    frame_end();
    set_enable(1);

    // Reset mid-frame with buffered pixels
    frame_start();
    out_ready = 0;
    send_line(10, 0);
    repeat (2) tick();
    check("buffered_valid", out_valid, 1);
    reset = 1; tick();
    check("reset_flush", out_valid, 0);
    reset = 0;
    sb_q.delete();
    model_active = 0; model_armed = enable; model_sof = 0;
    check("reset_line_cnt", line_cnt, 0);
    check("reset_busy", busy, 0);
    out_ready = 1;
    send_line(6, 0);
    drain();
    frame_end();

    // Randomised frames
    for (int f = 0; f < 8; f++) begin
      int nl;
      set_enable($urandom_range(0, 4) != 0);
      frame_start();
      check("busy_rand", busy, model_active);
      nl = $urandom_range(1, 4);
      for (int l = 0; l < nl; l++) begin
        send_line($urandom_range(1, 16), 1);
        drain();
      end
      frame_end();
    end
    check("ovf_final", overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/cam_capture.md
CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 8: camera data bus width.
REQ-002 SHALL have parameter BPP, default 2, legal 1..4: bus beats per pixel.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, power of two >= 2: output buffer depth in pixels.
REQ-004 SHALL have parameter CNT_W, default 10: width of line and pixel counters.
REQ-005 SHALL have port clk, input, 1: sole clock; the camera pixel clock is already distributed as clk, and all camera inputs are registered in this domain.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port cam_dat, input, DATA_W: registered camera data.
REQ-008 SHALL have port cam_href, input, 1: line-active qualifier.
REQ-009 SHALL have port cam_vsync, input, 1: high during vertical blanking.
REQ-010 SHALL have port enable, input, 1: capture request.
REQ-011 SHALL have port clear_ovf, input, 1: clears overflow.
REQ-012 SHALL have port out_data, output, DATA_W*BPP: packed pixel.
REQ-013 SHALL have port out_sof, output, 1: the pixel is the first of its frame.
REQ-014 SHALL have port out_sol, output, 1: the pixel is the first of its line.
REQ-015 SHALL have port out_valid, output, 1: FIFO head is valid.
REQ-016 SHALL have port out_ready, input, 1: consumer accepts.
REQ-017 SHALL have port line_cnt, output, CNT_W: completed lines in the current frame.
REQ-018 SHALL have port overflow, output, 1: sticky drop flag.
REQ-019 SHALL have port busy, output, 1: FSM is in state ACTIVE.

Function
REQ-020 SHALL implement FSM IDLE -> WAIT_FRAME when enable=1; WAIT_FRAME -> ACTIVE on a cam_vsync falling edge (previous sample 1, current sample 0); ACTIVE -> WAIT_FRAME on a cam_vsync rising edge if enable=1, else -> IDLE.
REQ-021 SHALL, in WAIT_FRAME, go to IDLE on the next cycle if enable=0; deassertion of enable in ACTIVE SHALL take effect only at frame end (REQ-020).
REQ-022 SHALL, in ACTIVE with cam_href=1, shift each cam_dat beat into a pack register, first beat in the MSBs; a pixel completes on beat BPP.
REQ-023 SHALL reset the beat count to 0 on every cam_href falling edge; a partial pixel at that point SHALL be discarded silently.
REQ-024 SHALL set out_sol on the first completed pixel after each cam_href rising edge, and out_sof on the first completed pixel after entering ACTIVE.
REQ-025 SHALL increment line_cnt, saturating at 2^CNT_W-1, on each cam_href falling edge in ACTIVE, and SHALL clear it on entry to ACTIVE.
REQ-026 SHALL write each completed pixel {sof, sol, data} into the FIFO in the cycle after the last beat is sampled; latency from last-beat sample to out_valid=1 into an empty FIFO SHALL be 2 cycles.
REQ-027 SHALL have FIFO output semantics: out_data, out_sof and out_sol held stable while out_valid=1 and out_ready=0; pop on out_valid & out_ready.
REQ-028 SHALL accept a write and a pop in the same cycle when full; when the FIFO is full with no pop, SHALL drop the completed pixel and set overflow.
REQ-029 SHALL keep overflow set until clear_ovf=1; a simultaneous drop and clear_ovf SHALL leave overflow=1.
REQ-030 SHALL carry a dropped sof/sol marker forward onto the next pixel that is successfully written in the same frame/line.
REQ-031 SHALL let the FIFO drain in any state; pointers SHALL wrap modulo FIFO_DEPTH, with separate full/empty detection via an extra pointer bit.

Reset
REQ-032 SHALL, with reset=1 at a clk edge, set: FSM=IDLE, FIFO empty, out_valid=0, out_sof=0, out_sol=0, out_data=0, line_cnt=0, overflow=0, busy=0, beat count=0, edge-detect history=0.
REQ-033 SHALL, on reset mid-frame, discard all buffered pixels and require a fresh vsync falling edge before capture resumes.

Verification
REQ-034 SHALL pass this test: BPP=2, enable=1, vsync 1->0, href high for 4 beats 0x12,0x34,0x56,0x78, out_ready=1 -> pixels 0x1234 (sof=1, sol=1) then 0x5678 (sof=0, sol=0); line_cnt=1 after href falls.
REQ-035 SHALL pass this test: href high for 3 beats -> one pixel output; the 3rd beat is discarded; the next line's first pixel has sol=1.
REQ-036 SHALL pass this test: FIFO_DEPTH=8, out_ready=0, 10 pixels -> 8 buffered, overflow=1; clear_ovf=1 in the same cycle as a drop -> overflow stays 1; clear_ovf in a later cycle -> overflow=0.
REQ-037 SHALL pass this test: enable dropped mid-frame -> capture continues to the vsync rising edge, then IDLE; the next frame produces no output.
REQ-038 SHALL pass this test: reset asserted with 5 pixels buffered -> out_valid=0 on the next cycle; href activity before the next vsync falling edge -> no output.
REQ-039 SHALL pass this test: full FIFO with out_ready=1 and a simultaneous pixel write -> no drop, occupancy stays 8, overflow=0.
